// File: rtl/div_chain_pkg.sv
// Shared types and helpers for the cochlea clock-tree sequencer.
// Holds the FSM state encoding, the default core count and the frame length helper.
package div_chain_pkg;

    localparam int DEF_N_CORES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Length of a frame whose counter is (n-1) bits wide.
    function automatic int frame_len(input int n);
        return 1 << (n - 1);
    endfunction

endpackage

// File: rtl/div_chain_ctrl_clk_gate.sv
// Glitch-free clock gate: low-transparent enable latch followed by an AND.
// The latch is cleared while rstb is low so the gated clock stays low in reset.
module clk_gate_cell (
    input  logic clk,
    input  logic rstb,
    input  logic en_i,
    output logic gclk_o
);

    logic en_l;

    // Enable latch: follows en_i only while clk is low, held while clk is high.
    always_latch begin
        if (!rstb) begin
            en_l = 1'b0;
        end else if (!clk) begin
            en_l = en_i;
        end
    end

    assign gclk_o = clk & en_l;

endmodule

// File: rtl/div_chain_ctrl.sv
// Shared phase counter that issues power-of-two clock-enable strobes to the core array.
// Optional feature macro CCLK_GATE_EN adds per-core gated clocks on port core_cclk.
module div_chain_ctrl
    import div_chain_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int CNT_W   = (N_CORES > 1) ? N_CORES - 1 : 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic               stop,
    input  logic [N_CORES-1:0] mask_in,
    input  logic               mask_load,
    output logic [N_CORES-1:0] core_en,
    output logic               frame_tick,
    output logic               running,
`ifdef CCLK_GATE_EN
    output logic [N_CORES-1:0] core_cclk,
`endif
    output logic [N_CORES-1:0] mask_act
);

    localparam int              F        = frame_len(CNT_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_CORES-1:0] shadow_q;
    logic [N_CORES-1:0] act_q;
    logic [N_CORES-1:0] core_en_d;
    logic               run_w;
    logic               last_w;

    assign run_w  = (state_q != IDLE);
    assign last_w = (cnt_q == CNT_LAST);

    // Sequencer FSM and phase counter; a stop only ends the run at a frame boundary.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start && !stop) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop && last_w) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        if (stop) begin
                            state_q <= DRAIN;
                        end
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last_w) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Shadow/active masks; while running the active mask only changes on the frame wrap.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shadow_q <= '0;
            act_q    <= '0;
        end else begin
            if (mask_load) begin
                shadow_q <= mask_in;
            end
            if (!run_w) begin
                if (mask_load) begin
                    act_q <= mask_in;
                end
            end else if (last_w) begin
                act_q <= mask_load ? mask_in : shadow_q;
            end
        end
    end

    // Strobe decode: core i fires when the low i counter bits are all zero.
    always_comb begin
        logic [CNT_W-1:0] lowm;
        lowm      = '0;
        core_en_d = '0;
        for (int i = 0; i < N_CORES; i++) begin
            lowm         = CNT_W'((1 << i) - 1);
            core_en_d[i] = run_w & act_q[i] & ((cnt_q & lowm) == '0);
        end
    end

    assign core_en    = core_en_d;
    assign frame_tick = run_w & last_w;
    assign running    = run_w;
    assign mask_act   = act_q;

`ifdef CCLK_GATE_EN
    for (genvar g = 0; g < N_CORES; g++) begin : g_gate
        clk_gate_cell u_gate (
            .clk    (clk),
            .rstb   (rstb),
            .en_i   (core_en_d[g]),
            .gclk_o (core_cclk[g])
        );
    end
`endif

endmodule

// File: tb/tb_div_chain_ctrl.sv
// Self-checking bench for div_chain_ctrl with N_CORES=4 (frame of 8 cycles).
// Directed scenarios plus a random run compared against a cycle-level behavioural model.
module tb_div_chain_ctrl;

    localparam int N = 4;
    localparam int F = 8;

    logic         clk;
    logic         rstb;
    logic         start;
    logic         stop;
    logic [N-1:0] mask_in;
    logic         mask_load;
    logic [N-1:0] core_en;
    logic         frame_tick;
    logic         running;
    logic [N-1:0] mask_act;
`ifdef CCLK_GATE_EN
    logic [N-1:0] core_cclk;
    int           gcnt;
`endif

    int checks;
    int passes;
    int fails;

    div_chain_ctrl #(.N_CORES(N)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .stop       (stop),
        .mask_in    (mask_in),
        .mask_load  (mask_load),
        .core_en    (core_en),
        .frame_tick (frame_tick),
        .running    (running),
`ifdef CCLK_GATE_EN
        .core_cclk  (core_cclk),
`endif
        .mask_act   (mask_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CCLK_GATE_EN
    always @(posedge core_cclk[2]) gcnt++;
`endif

    // Behavioural model: run flag, phase within the frame, pending stop, masks.
    bit           m_run;
    bit           m_stopping;
    int           m_ph;
    logic [N-1:0] m_sh;
    logic [N-1:0] m_act;

    wire [2*N+1:0] obs = {running, frame_tick, mask_act, core_en};

    function automatic logic [2*N+1:0] mexp();
        logic [N-1:0] ce;
        ce = '0;
        for (int i = 0; i < N; i++)
            ce[i] = m_run && m_act[i] && ((m_ph % (1 << i)) == 0);
        return {m_run, m_run && (m_ph == F - 1), m_act, ce};
    endfunction

    task automatic model_reset();
        m_run      = 0;
        m_stopping = 0;
        m_ph       = 0;
        m_sh       = '0;
        m_act      = '0;
    endtask

    // One master cycle: model consumes the inputs present at the posedge.
    task automatic tick();
        logic         st, sp, ml;
        logic [N-1:0] mi, sh_old;
        bit           wrap;
        st = start; sp = stop; ml = mask_load; mi = mask_in;
        @(posedge clk);
        wrap   = m_run && (m_ph == F - 1);
        sh_old = m_sh;
        if (ml) m_sh = mi;
        if (!m_run) begin
            if (ml) m_act = mi;
            if (st && !sp) begin
                m_run      = 1;
                m_ph       = 0;
                m_stopping = 0;
            end
        end else begin
            if (wrap) m_act = ml ? mi : sh_old;
            if (sp) m_stopping = 1;
            if (m_stopping && wrap) begin
                m_run = 0;
                m_ph  = 0;
            end else begin
                m_ph = (m_ph + 1) % F;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 0; start = 0; stop = 0; mask_in = '0; mask_load = 0;
        model_reset();
        #12;
        checks++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 10'h0);
        end else passes++;
        @(negedge clk);
        rstb = 1;
        tick();
        checks++;
        if (obs !== mexp()) begin
            fails++;
            $display("FAIL reset_release got=%h want=%h", obs, mexp());
        end else passes++;
    endtask

    task automatic test_mask_idle();
        mask_in = 4'hF; mask_load = 1;
        tick();
        mask_load = 0; mask_in = '0;
        checks++;
        if (mask_act !== 4'hF) begin
            fails++;
            $display("FAIL idle_mask_act got=%h want=%h", mask_act, 4'hF);
        end else passes++;
        checks++;
        if (core_en !== 4'h0 || running !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet got=%h/%b want=0/0", core_en, running);
        end else passes++;
    endtask

    task automatic test_start();
        bit ft, c3, c1;
        start = 1;
        tick();
        start = 0;
        checks++;
        if (core_en !== 4'hF) begin
            fails++;
            $display("FAIL start_all_strobe got=%h want=%h", core_en, 4'hF);
        end else passes++;
        for (int k = 2; k <= 24; k++) begin
            tick();
            ft = (k % 8) == 0;
            c3 = ((k - 1) % 8) == 0;
            c1 = ((k - 1) % 2) == 0;
            checks++;
            if (frame_tick !== ft || core_en[3] !== c3 || core_en[1] !== c1) begin
                fails++;
                $display("FAIL start_k%0d got ft=%b c3=%b c1=%b want ft=%b c3=%b c1=%b",
                         k, frame_tick, core_en[3], core_en[1], ft, c3, c1);
            end else passes++;
            checks++;
            if (obs !== mexp()) begin
                fails++;
                $display("FAIL start_model k%0d got=%h want=%h", k, obs, mexp());
            end else passes++;
        end
    endtask

    task automatic test_stop();
        int n;
        for (int j = 0; j < 16 && m_ph != 2; j++) tick();
        stop = 1;
        tick();
        stop = 0;
        n = 0;
        for (int j = 0; j < 20 && running; j++) begin
            n++;
            checks++;
            if (core_en[3] !== 1'b0) begin
                fails++;
                $display("FAIL drain_c3 got=%b want=0", core_en[3]);
            end else passes++;
            stop = (j == 1);
            tick();
            stop = 0;
            checks++;
            if (obs !== mexp()) begin
                fails++;
                $display("FAIL drain_model got=%h want=%h", obs, mexp());
            end else passes++;
        end
        checks++;
        if (n != 5 || running !== 1'b0) begin
            fails++;
            $display("FAIL drain_len got=%0d/%b want=5/0", n, running);
        end else passes++;
    endtask

    task automatic test_mask_run();
        start = 1;
        tick();
        start = 0;
        for (int j = 0; j < 16 && m_ph != 3; j++) tick();
        mask_in = 4'h5; mask_load = 1;
        tick();
        mask_load = 0; mask_in = '0;
        for (int c = 4; c <= 7; c++) begin
            checks++;
            if (mask_act !== 4'hF) begin
                fails++;
                $display("FAIL mask_hold c%0d got=%h want=%h", c, mask_act, 4'hF);
            end else passes++;
            tick();
        end
        for (int c = 0; c <= 7; c++) begin
            checks++;
            if (mask_act !== 4'h5 || (core_en & 4'hA) !== 4'h0) begin
                fails++;
                $display("FAIL mask_apply c%0d got=%h/%h want=5/0", c, mask_act, core_en & 4'hA);
            end else passes++;
            checks++;
            if (obs !== mexp()) begin
                fails++;
                $display("FAIL mask_model c%0d got=%h want=%h", c, obs, mexp());
            end else passes++;
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
        for (int j = 0; j < 20 && running; j++) tick();
    endtask

    task automatic test_start_stop_idle();
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        checks++;
        if (running !== 1'b0 || obs !== mexp()) begin
            fails++;
            $display("FAIL start_stop_idle got=%h want=%h", obs, mexp());
        end else passes++;
    endtask

    task automatic test_reset_mid();
        mask_in = 4'hF; mask_load = 1;
        tick();
        mask_load = 0;
        start = 1;
        tick();
        start = 0;
        for (int j = 0; j < 16 && m_ph != 5; j++) tick();
        #2 rstb = 0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL async_reset got=%h want=%h", obs, 10'h0);
        end else passes++;
        @(negedge clk);
        rstb = 1;
        tick();
        checks++;
        if (running !== 1'b0 || obs !== mexp()) begin
            fails++;
            $display("FAIL after_reset got=%h want=%h", obs, mexp());
        end else passes++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            start     = ($urandom_range(0, 9) == 0);
            stop      = ($urandom_range(0, 11) == 0);
            mask_load = ($urandom_range(0, 5) == 0);
            mask_in   = N'($urandom);
            tick();
            checks++;
            if (obs !== mexp()) begin
                fails++;
                $display("FAIL random k%0d got=%h want=%h", k, obs, mexp());
            end else passes++;
        end
        start = 0; stop = 0; mask_load = 0;
    endtask

`ifdef CCLK_GATE_EN
    task automatic test_gate();
        stop = 1;
        tick();
        stop = 0;
        for (int j = 0; j < 20 && running; j++) tick();
        mask_in = 4'hF; mask_load = 1;
        tick();
        mask_load = 0;
        start = 1;
        tick();
        start = 0;
        gcnt = 0;
        for (int j = 0; j < 16; j++) tick();
        checks++;
        if (gcnt != 4) begin
            fails++;
            $display("FAIL gate_pulses got=%0d want=4", gcnt);
        end else passes++;
    endtask
`endif

    initial begin
        checks = 0; passes = 0; fails = 0;
        test_reset();
        test_mask_idle();
        test_start();
        test_stop();
        test_mask_run();
        test_start_stop_idle();
        test_reset_mid();
        test_random();
`ifdef CCLK_GATE_EN
        test_gate();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
